// File: rtl/framebuffer_single_port.sv
// framebuffer_single_port
// Single-port 16-bit color framebuffer. It answers the fragment pipeline's
// reads and commits its writes while idle. It also provides a clear engine
// that fills the memory with a constant, and an AXI-Stream transmitter that
// sends the whole frame through a 2-entry output FIFO.
module framebuffer_single_port #(
  parameter int FRAMEBUFFER_INDEX_WIDTH   = 14,
  parameter int FRAMEBUFFER_SIZE_IN_WORDS = 16384
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexRead,
  output logic [15:0]                        colorIn,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexWrite,
  input  logic                               colorWriteEnable,
  input  logic [15:0]                        colorOut,
  input  logic                               cmdClear,
  input  logic                               cmdStream,
  input  logic [15:0]                        clearColor,
  output logic                               busy,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [15:0]                        m_axis_tdata
);

  localparam int IW   = FRAMEBUFFER_INDEX_WIDTH;
  localparam int SIZE = FRAMEBUFFER_SIZE_IN_WORDS;
  localparam logic [IW-1:0] LAST_ADDR = IW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Pixel storage. It is not reset, so a clear that is aborted leaves
  // whatever it had already written.
  logic [15:0] mem [SIZE];

  state_t        state_reg;
  logic [IW-1:0] addr_reg;
  logic [15:0]   fill_reg;
  logic          rd_done_reg;
  logic          busy_reg;
  logic [15:0]   color_in_reg;

  // Output FIFO bookkeeping (two slots).
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0][15:0] slot_data;
  logic [1:0]    slot_last;

  // Shared memory port.
  logic          port_we;
  logic [IW-1:0] port_addr;
  logic [15:0]   port_wdata;
  logic [15:0]   port_rdata;
  logic          pipe_rd;
  logic          issue;
  logic          pop;
  logic          at_last;

  // Arbitration of the single port. The pipeline owns it in IDLE, and there
  // a write beats a read. The engines own it in CLEAR and STREAM, where
  // pipeline writes are dropped.
  always_comb begin
    port_we    = 1'b0;
    port_addr  = addr_reg;
    port_wdata = fill_reg;
    pipe_rd    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (colorWriteEnable) begin
          port_we    = 1'b1;
          port_addr  = colorIndexWrite;
          port_wdata = colorOut;
        end else begin
          port_addr = colorIndexRead;
          pipe_rd   = 1'b1;
        end
      end
      CLEAR: begin
        port_we = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign port_rdata = mem[port_addr];
  assign at_last    = (addr_reg == LAST_ADDR);

  // Read data lands in a FIFO slot on the edge that ends the read cycle.
  // Because of that there is never a read still in flight across an edge,
  // and the "occupancy plus in-flight below two" rule reduces to a check on
  // occupancy alone.
  assign issue = (state_reg == STREAM) && !rd_done_reg && (count_reg < 2'd2);

  assign m_axis_tvalid = (count_reg != 2'd0);
  assign m_axis_tdata  = slot_data[rd_ptr_reg];
  assign m_axis_tlast  = m_axis_tvalid & slot_last[rd_ptr_reg];
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign busy          = busy_reg;
  assign colorIn       = color_in_reg;

  // Memory write port.
  always_ff @(posedge clk) begin
    if (port_we) begin
      mem[port_addr] <= port_wdata;
    end
  end

  // Pipeline read data register. It holds its value on every cycle that
  // does not service a pipeline read.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_in_reg <= 16'h0000;
    end else if (pipe_rd) begin
      color_in_reg <= port_rdata;
    end
  end

  // One FIFO slot per generate iteration. Each slot captures read data and
  // a last-pixel flag when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
      logic [15:0] data_reg;
      logic        last_reg;

      // Slot capture on an issued stream read.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg <= 16'h0000;
          last_reg <= 1'b0;
        end else if (issue && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= port_rdata;
          last_reg <= at_last;
        end
      end

      assign slot_data[gi] = data_reg;
      assign slot_last[gi] = last_reg;
    end
  endgenerate

  // Control FSM. It handles command acceptance, the clear sweep, the stream
  // read sweep and the FIFO pointers. busy is registered, so it rises the
  // cycle after a command is accepted and falls on the edge that returns
  // the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      fill_reg    <= 16'h0000;
      rd_done_reg <= 1'b0;
      busy_reg    <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmdClear) begin
            fill_reg  <= clearColor;
            addr_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= CLEAR;
          end else if (cmdStream) begin
            addr_reg    <= '0;
            rd_done_reg <= 1'b0;
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            busy_reg    <= 1'b1;
            state_reg   <= STREAM;
          end
        end
        CLEAR: begin
          if (at_last) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            addr_reg <= addr_reg + 1'b1;
          end
        end
        STREAM: begin
          if (issue) begin
            wr_ptr_reg <= ~wr_ptr_reg;
            if (at_last) begin
              rd_done_reg <= 1'b1;
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
          if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
            if (slot_last[rd_ptr_reg]) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
          case ({issue, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
          endcase
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_single_port.sv
// Testbench for framebuffer_single_port. It uses a behavioural memory model
// and two scoreboard queues: one for colorIn responses and one for stream
// pixels. A monitor on the falling edge pops and compares both queues.
module tb_framebuffer_single_port;
  localparam int IW = 4;
  localparam int SZ = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] colorIndexRead = '0;
  logic [15:0]   colorIn;
  logic [IW-1:0] colorIndexWrite = '0;
  logic          colorWriteEnable = 1'b0;
  logic [15:0]   colorOut = 16'h0;
  logic          cmdClear = 1'b0;
  logic          cmdStream = 1'b0;
  logic [15:0]   clearColor = 16'h0;
  logic          busy;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [15:0]   m_axis_tdata;

  framebuffer_single_port #(
    .FRAMEBUFFER_INDEX_WIDTH(IW),
    .FRAMEBUFFER_SIZE_IN_WORDS(SZ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .colorIndexRead(colorIndexRead),
    .colorIn(colorIn),
    .colorIndexWrite(colorIndexWrite),
    .colorWriteEnable(colorWriteEnable),
    .colorOut(colorOut),
    .cmdClear(cmdClear),
    .cmdStream(cmdStream),
    .clearColor(clearColor),
    .busy(busy),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] v; } color_exp_t;
  typedef struct packed { logic [15:0] d; logic l; } px_t;

  color_exp_t  exp_color[$];
  px_t         exp_stream[$];
  logic [15:0] ref_mem [SZ];
  logic [15:0] model_color = 16'h0;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares colorIn against due responses and checks each stream
  // handshake against the pixel queue. It also enforces AXIS stability.
  color_exp_t  mon_c;
  px_t         mon_p;
  logic        prev_stall = 1'b0;
  logic [15:0] stall_d = 16'h0;
  logic        stall_l = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      while (exp_color.size() > 0 && exp_color[0].due <= cyc) begin
        mon_c = exp_color.pop_front();
        check("colorIn", colorIn, mon_c.v);
      end
      if (prev_stall) begin
        check("tvalid_held", m_axis_tvalid, 1'b1);
        check("tdata_stable", m_axis_tdata, stall_d);
        check("tlast_stable", m_axis_tlast, stall_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("pixel_expected", 32'(exp_stream.size() != 0), 32'd1);
        if (exp_stream.size() != 0) begin
          mon_p = exp_stream.pop_front();
          check("tdata", m_axis_tdata, mon_p.d);
          check("tlast", m_axis_tlast, mon_p.l);
        end
        hs_count++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      stall_d    = m_axis_tdata;
      stall_l    = m_axis_tlast;
    end
  end

  // Sync the colorIn model with the idle read of colorIndexRead.
  task automatic burst_start();
    model_color = ref_mem[colorIndexRead];
  endtask

  task automatic burst_end();
    @(posedge clk); #1;
    colorWriteEnable = 1'b0;
  endtask

  task automatic pipe_op(input logic we, input int widx, input logic [15:0] wd, input int ridx);
    color_exp_t e;
    @(posedge clk); #1;
    colorWriteEnable = we;
    colorIndexWrite  = widx[IW-1:0];
    colorOut         = wd;
    colorIndexRead   = ridx[IW-1:0];
    if (we) ref_mem[widx] = wd;
    else    model_color = ref_mem[ridx];
    e.due = cyc + 1;
    e.v   = model_color;
    exp_color.push_back(e);
    $display("pipe we=%0d widx=%0d wdata=0x%04h ridx=%0d expect_colorIn=0x%04h", we, widx, wd, ridx, model_color);
  endtask

  task automatic run_clear(input logic [15:0] color, input logic with_stream);
    int cnt;
    int done_n;
    @(posedge clk); #1;
    colorWriteEnable = 1'b0;
    cmdClear = 1'b1;
    cmdStream = with_stream;
    clearColor = color;
    cnt = 0;
    done_n = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      cmdClear = 1'b0;
      cmdStream = 1'b0;
      clearColor = 16'h0;
      @(negedge clk);
      if (busy) cnt++;
      else begin
        done_n = n;
        break;
      end
    end
    check("clear_busy_cycles", 32'(cnt), 32'd16);
    check("clear_done_cycle", 32'(done_n), 32'd17);
    for (int i = 0; i < SZ; i++) ref_mem[i] = color;
    if (with_stream) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("dropped_stream_busy", busy, 1'b0);
      check("dropped_stream_tvalid", m_axis_tvalid, 1'b0);
    end
    $display("clear color=0x%04h with_stream=%0d busy_cycles=%0d", color, with_stream, cnt);
  endtask

  // mode 0: tready held high, with latency checks; mode 1: tready starts
  // 1,0,0,1 then goes random, and ignored commands are injected mid-stream.
  // abort_at != 0 asserts reset in that cycle.
  task automatic run_stream(input int mode, input int abort_at);
    int first_v;
    int last_c;
    int done_n;
    px_t p;
    @(posedge clk); #1;
    colorWriteEnable = 1'b0;
    cmdStream = 1'b1;
    m_axis_tready = (mode == 0);
    for (int i = 0; i < SZ; i++) begin
      p.d = ref_mem[i];
      p.l = (i == SZ - 1);
      exp_stream.push_back(p);
    end
    hs_count = 0;
    first_v = -1;
    last_c = -1;
    done_n = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      cmdStream = 1'b0;
      cmdClear = 1'b0;
      reset = 1'b0;
      if (mode == 1) begin
        if (n <= 4) m_axis_tready = (n == 1 || n == 4);
        else        m_axis_tready = 1'($urandom_range(0, 1));
        if (n == 5) begin
          cmdStream = 1'b1;
          cmdClear = 1'b1;
          clearColor = 16'h1234;
        end
      end
      if (abort_at != 0 && n == abort_at) begin
        reset = 1'b1;
        m_axis_tready = 1'b0;
        exp_stream.delete();
      end
      @(negedge clk);
      if (n == 1) begin
        check("stream_busy_rise", busy, 1'b1);
        check("stream_no_early_valid", m_axis_tvalid, 1'b0);
      end
      if (abort_at != 0 && n == abort_at + 1) begin
        check("abort_tvalid", m_axis_tvalid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_tlast", m_axis_tlast, 1'b0);
        check("abort_tdata", m_axis_tdata, 16'h0);
        done_n = n;
        break;
      end
      if (m_axis_tvalid && first_v < 0) first_v = n;
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) last_c = n;
      if (!busy && n > 1 && abort_at == 0) begin
        done_n = n;
        break;
      end
    end
    check("stream_finished", 32'(done_n > 0), 32'd1);
    if (abort_at == 0) begin
      check("stream_handshakes", 32'(hs_count), 32'(SZ));
      check("stream_queue_empty", 32'(exp_stream.size()), 32'd0);
      if (mode == 0) begin
        check("first_tvalid_cycle", 32'(first_v), 32'd2);
        check("tlast_cycle", 32'(last_c), 32'(SZ + 1));
        check("busy_fall_cycle", 32'(done_n), 32'(SZ + 2));
      end
    end
    $display("stream mode=%0d abort_at=%0d handshakes=%0d first_valid=%0d last=%0d done=%0d",
             mode, abort_at, hs_count, first_v, last_c, done_n);
    m_axis_tready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SZ; i++) ref_mem[i] = 16'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_colorIn", colorIn, 16'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_tlast", m_axis_tlast, 1'b0);
    check("reset_tdata", m_axis_tdata, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Give the memory known contents first.
    run_clear(16'h0000, 1'b0);

    // Directed write/read and write-wins-with-hold cases.
    burst_start();
    pipe_op(1'b1, 5, 16'hABCD, 0);
    pipe_op(1'b0, 0, 16'h0, 5);
    pipe_op(1'b1, 3, 16'h1111, 7);
    pipe_op(1'b0, 0, 16'h0, 3);
    pipe_op(1'b0, 0, 16'h0, 7);
    burst_end();

    // Random pipeline traffic.
    burst_start();
    for (int k = 0; k < 40; k++) begin
      pipe_op(1'((k != 0) && ($urandom_range(0, 2) == 0)), $urandom_range(0, SZ - 1),
              16'($urandom), $urandom_range(0, SZ - 1));
    end
    burst_end();

    // Memory address i holds i.
    burst_start();
    for (int i = 0; i < SZ; i++) pipe_op(1'b1, i, 16'(i), 0);
    for (int k = 0; k < 8; k++) pipe_op(1'b0, 0, 16'h0, $urandom_range(0, SZ - 1));
    burst_end();

    run_stream(0, 0);
    run_stream(1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ignored_cmd_busy", busy, 1'b0);
    end

    // Clear and stream requested together: only the clear happens.
    run_clear(16'hF800, 1'b1);
    run_stream(0, 0);

    // Reset mid-stream, then a full stream restarting at address 0.
    burst_start();
    for (int i = 0; i < SZ; i++) pipe_op(1'b1, i, 16'(i + 16'h0100), 0);
    burst_end();
    run_stream(0, 5);
    run_stream(1, 0);

    // Pipeline read-back after the engines have run.
    burst_start();
    pipe_op(1'b0, 0, 16'h0, 9);
    pipe_op(1'b1, 9, 16'h5A5A, 2);
    pipe_op(1'b0, 0, 16'h0, 9);
    burst_end();

    repeat (3) @(negedge clk);
    check("color_queue_empty", 32'(exp_color.size()), 32'd0);
    check("stream_queue_final", 32'(exp_stream.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_single_port.md
# framebuffer_single_port

Single-port color framebuffer that serves the fragment pipeline's read/write accesses on iCE40-class targets and streams the finished frame to the display side. The fragment stream is throttled to one fragment every other clock, so a single-port memory is sufficient. This block is the memory side of that scheme: it answers the pipeline's reads, commits its writes, and adds a clear engine and an AXI-Stream frame transmitter.

## Interface
- FRAMEBUFFER_INDEX_WIDTH, 14, width of pixel index
- FRAMEBUFFER_SIZE_IN_WORDS, 16384, number of 16-bit pixels; must be ≤ 2**FRAMEBUFFER_INDEX_WIDTH

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- colorIndexRead  in  FRAMEBUFFER_INDEX_WIDTH  pipeline read address, driven every cycle
- colorIn  out  16  read data to pipeline
- colorIndexWrite  in  FRAMEBUFFER_INDEX_WIDTH  pipeline write address
- colorWriteEnable  in  1  pipeline write strobe
- colorOut  in  16  pipeline write data
- cmdClear  in  1  single-cycle request: fill memory with clearColor
- cmdStream  in  1  single-cycle request: transmit whole frame
- clearColor  in  16  fill value, sampled on cmdClear acceptance
- busy  out  1  clear or stream in progress
- m_axis_tvalid  out  1  frame stream valid
- m_axis_tready  in  1  frame stream ready
- m_axis_tlast  out  1  high on the last pixel of the frame
- m_axis_tdata  out  16  pixel

## Operation
- FSM states: IDLE, CLEAR, STREAM.
- IDLE, pipeline service:
  - If colorWriteEnable is high, write colorOut to colorIndexWrite. The write always wins the port.
  - Otherwise read colorIndexRead. colorIn is registered and updates one cycle after the read cycle.
  - On a write cycle, colorIn holds its previous value.
- Command acceptance, IDLE only:
  - cmdClear takes priority when cmdClear and cmdStream are both high; the stream request is dropped.
  - Commands arriving outside IDLE are ignored.
- CLEAR:
  - Writes clearColor to addresses 0 to FRAMEBUFFER_SIZE_IN_WORDS-1, one per cycle in ascending order.
  - Returns to IDLE after the last write.
- STREAM:
  - Reads addresses 0 to SIZE-1 in ascending order into a 2-entry output FIFO.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2, so no data is lost under backpressure.
  - m_axis_tdata and m_axis_tvalid come from the FIFO head.
  - m_axis_tlast is high with the pixel at address SIZE-1.
  - Returns to IDLE on the handshake (tvalid && tready) of the last pixel.
- During CLEAR and STREAM, pipeline writes are dropped and colorIn holds its value. The caller guarantees the pipeline is idle.
- Address counter is FRAMEBUFFER_INDEX_WIDTH bits wide with a terminal compare at SIZE-1; it never wraps past SIZE-1.
- Memory contents are not reset.

## Timing
- Reset values: colorIn=0, busy=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-CLEAR or mid-STREAM aborts immediately; partially cleared memory keeps what was written.
- Pipeline read latency: colorIn is valid one cycle after the index is presented in a non-write cycle.
- Write latency: a write in cycle n is visible to a read issued in cycle n+1.
- busy:
  - Rises the cycle after command acceptance.
  - For CLEAR, falls the cycle after the last write, so busy is high for exactly SIZE cycles.
  - For STREAM, falls the cycle after the tlast handshake.
- Stream latency:
  - Command accepted in cycle 0, first read in cycle 1, m_axis_tvalid with pixel 0 in cycle 2.
  - With tready held high: one pixel per cycle; last pixel presented in cycle SIZE+1.
- AXIS rules:
  - tvalid is never retracted before its handshake.
  - tdata and tlast stay stable while tvalid && !tready.
- A new command is accepted the cycle busy reads low.

## Test plan
Bench parameters: width 4, size 16.
- Reset, then pipeline writes 0xABCD to index 5, then reads index 5 the next cycle -> colorIn=0xABCD one cycle after the read.
- colorWriteEnable=1 (idx 3, 0x1111) in the same cycle as colorIndexRead=7 -> write commits; colorIn keeps its prior value.
- cmdClear with clearColor=0xF800 -> busy high for exactly 16 cycles; a following stream returns 16 × 0xF800 with tlast only on the 16th.
- cmdStream after memory holds address i = i, tready=1 -> tvalid from cycle 2; data 0..15 on consecutive cycles; tlast with data 15; busy drops the following cycle.
- Same stream with tready toggling 1,0,0,1 (pseudo-random) -> no pixel lost or duplicated; data stable while stalled; 16 handshakes in order.
- cmdClear and cmdStream in the same cycle -> clear only. cmdStream while busy -> ignored. Reset at cycle 5 of a stream -> tvalid=0 and busy=0 next cycle; the next cmdStream starts from address 0.
